vector_issue_sched: RTL
=======================

# vector_issue_sched

Issue scheduler sitting between the vector register remapper and the vector lanes / memory unit. Buffers remapped vector instructions in a small in-order FIFO and tracks a per-physical-vreg scoreboard of pending writes and memory locks. Releases the head instruction only when it is hazard-free. Reconfigure instructions are held until the scoreboard fully drains, so a register-grouping change never races in-flight work.

## Interface
- VECTOR_REGISTERS, 32: physical vregs tracked; REGISTER_BITS = $clog2(VECTOR_REGISTERS).
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock, asynchronous, active-low.
- valid_i  in  1  remapped instruction offered.
- instr_i  in  remapped_v_instr  uses fields dst, src1, src2, lock, reconfigure, microop.
- ready_o  out  1  FIFO can accept.
- valid_o  out  1  head instruction issuable.
- instr_o  out  remapped_v_instr  head instruction, unmodified.
- ready_i  in  1  downstream accepts.
- wb_valid_i  in  1  a lane/load writeback completed.
- wb_dst_i  in  REGISTER_BITS  vreg whose pending bit clears.
- unlock_valid_i  in  1  memory unit released a locked vreg.
- unlock_dst_i  in  REGISTER_BITS  vreg whose lock bit clears.
- flush_i  in  1  synchronous flush of FIFO and scoreboard.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- is_idle_o  out  1  FIFO empty and scoreboard clear.

## Operation
- Store: microop[instr_opcode_msb_c -: 3]==3'b010. All other non-reconfigure instructions are writers.
- Scoreboard: pending[VECTOR_REGISTERS] and locked[VECTOR_REGISTERS].
- Hazard: pending or locked set for any of head.src1, head.src2, head.dst. All three are always checked (conservative, no opcode decode).
- FSM states: RUN and DRAIN; reset state is RUN.
  - RUN, head non-reconfigure: valid_o = !empty && !hazard.
  - RUN, head has reconfigure=1: valid_o=0 and the FSM moves to DRAIN.
  - DRAIN: valid_o = (pending==0 && locked==0). When the head issues, the FSM returns to RUN.
- Issue occurs on valid_o && ready_i. It pops the head.
  - Writer: sets pending[dst].
  - lock=1: sets locked[dst].
  - A store sets no pending bit.
  - Reconfigure sets no bits.
- wb_valid_i clears pending[wb_dst_i]. unlock_valid_i clears locked[unlock_dst_i]. A clear of an already-zero bit is a no-op.
- Same-cycle set and clear of the same bit: set wins.
- Enqueue on valid_i && ready_o. Enqueue and issue may occur in the same cycle; count is unchanged.
- flush_i has priority over everything:
  - FIFO emptied, pending and locked cleared, FSM to RUN.
  - Concurrent enqueue, issue, wb and unlock are all discarded.
  - Downstream must not treat a valid_o && ready_i in a flush cycle as issued.
- Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.

## Timing
- Reset values:
  - FIFO empty, count_o=0, pending=0, locked=0, state RUN.
  - ready_o=1, valid_o=0, is_idle_o=1.
  - instr_o is don't-care while valid_o=0.
- ready_o = (count < DEPTH), driven from registered count. When full there is no same-cycle pass-through, even if an issue occurs that cycle.
- valid_o and instr_o are combinational from FIFO head, scoreboard registers and state. There is no combinational path from valid_i or ready_i to valid_o.
- Latency: an instruction enqueued at edge N is visible at the head, and can issue, in the cycle after N when the FIFO was empty.
- Scoreboard has no bypass. A wb or unlock sampled at edge N unblocks the head from cycle N+1.
- Back-to-back dependent pair (B reads A.dst): B issues no earlier than one cycle after the edge that samples A's writeback.
- DRAIN exits the cycle after the last bit clears, provided ready_i is high.
- Asynchronous reset mid-operation drops all buffered instructions and scoreboard state immediately.

## Test plan
- Independent stream, ready_i=1:
  - Stimulus: enqueue dst 1,2,3,4 with sources 10,11 on consecutive cycles, no wb.
  - Required: issues on consecutive cycles with one-cycle latency; pending bits 1–4 set.
- RAW stall:
  - Stimulus: A dst=5 issues; B src1=5 enqueued; wb_dst_i=5 pulsed 6 cycles later.
  - Required: B held with valid_o=0 until the cycle after the wb edge, then issues.
- Lock and same-cycle priority:
  - Stimulus: load with lock=1, dst=7 issues; a writer to 7 waits; wb_dst_i=7 alone.
  - Required: writer stays blocked. After unlock_dst_i=7 it issues.
  - Also: an issue setting pending[3] in the same cycle as wb_dst_i=3 leaves pending[3]=1.
- Reconfigure drain:
  - Stimulus: two in-flight writers (dst 2,9) followed by reconfigure.
  - Required: state goes to DRAIN; reconfigure issues only the cycle after both wbs; no bits set; state returns to RUN.
- Full and wrap:
  - Stimulus: with ready_i=0, enqueue DEPTH=4 instructions.
  - Required: count_o=4, ready_o=0, a fifth valid_i is not accepted.
  - Then release ready_i and push 8 more. Required: in-order output across pointer wrap.
- Flush and reset:
  - Stimulus: flush_i with 3 queued instructions, pending=0x24, concurrent enqueue and wb.
  - Required: next cycle count_o=0, pending=0, is_idle_o=1, the enqueue is lost.
  - Stimulus: rstn_i low mid-DRAIN. Required: all outputs return to reset values immediately.

Source files
------------

// File: rtl/vector_issue_sched.sv
// ---------------------------------------------------------------------------
// vector_issue_sched
//
// Issue scheduler placed between the vector register remapper and the vector
// lanes / memory unit. Remapped instructions are buffered in a small in-order
// FIFO. A per-physical-vreg scoreboard tracks pending writes and memory locks.
// The head instruction is released only when none of its registers (src1,
// src2, dst) is pending or locked. A reconfigure instruction at the head moves
// the scheduler into DRAIN. It is then released only once the whole scoreboard
// is clear, so that a register-grouping change cannot race in-flight work.
//
// Instruction word layout (flat vector, LSB first):
//   [RB-1:0]          dst
//   [2RB-1:RB]        src1
//   [3RB-1:2RB]       src2
//   [3RB]             lock
//   [3RB+1]           reconfigure
//   [INSTR_W-1:3RB+2] microop (opcode class in microop[instr_opcode_msb_c -: 3])
//
// Ports:
//   clk_i           clock
//   rstn_i          asynchronous active-low reset
//   valid_i/instr_i remapped instruction offered; ready_o = FIFO can accept
//   valid_o/instr_o head instruction issuable; ready_i = downstream accepts
//   wb_valid_i/wb_dst_i         clears pending[wb_dst_i]
//   unlock_valid_i/unlock_dst_i clears locked[unlock_dst_i]
//   flush_i         synchronous flush of FIFO, scoreboard and FSM
//   count_o         FIFO occupancy (0..DEPTH)
//   is_idle_o       FIFO empty and scoreboard clear
// ---------------------------------------------------------------------------
module vector_issue_sched #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int DEPTH            = 4,
  parameter int MICROOP_W        = 8,
  localparam int REGISTER_BITS   = $clog2(VECTOR_REGISTERS),
  localparam int INSTR_W         = 3 * REGISTER_BITS + 2 + MICROOP_W,
  localparam int CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     valid_i,
  input  logic [INSTR_W-1:0]       instr_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [INSTR_W-1:0]       instr_o,
  input  logic                     ready_i,
  input  logic                     wb_valid_i,
  input  logic [REGISTER_BITS-1:0] wb_dst_i,
  input  logic                     unlock_valid_i,
  input  logic [REGISTER_BITS-1:0] unlock_dst_i,
  input  logic                     flush_i,
  output logic [CNT_W-1:0]         count_o,
  output logic                     is_idle_o
);

  localparam int PTR_W               = $clog2(DEPTH);
  localparam int DST_LSB             = 0;
  localparam int SRC1_LSB            = REGISTER_BITS;
  localparam int SRC2_LSB            = 2 * REGISTER_BITS;
  localparam int LOCK_BIT            = 3 * REGISTER_BITS;
  localparam int RECONF_BIT          = 3 * REGISTER_BITS + 1;
  localparam int UOP_LSB             = 3 * REGISTER_BITS + 2;
  localparam int instr_opcode_msb_c  = 6;
  localparam logic [2:0] OPC_STORE   = 3'b010;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;

  logic [INSTR_W-1:0]          r_mem [DEPTH];
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [CNT_W-1:0]            r_count;

  logic [VECTOR_REGISTERS-1:0] r_pending;
  logic [VECTOR_REGISTERS-1:0] r_locked;
  logic [VECTOR_REGISTERS-1:0] w_pending_nxt;
  logic [VECTOR_REGISTERS-1:0] w_locked_nxt;

  logic [INSTR_W-1:0]          w_head;
  logic [REGISTER_BITS-1:0]    w_dst;
  logic [REGISTER_BITS-1:0]    w_src1;
  logic [REGISTER_BITS-1:0]    w_src2;
  logic                        w_lock;
  logic                        w_reconf;
  logic                        w_store;
  logic                        w_empty;
  logic                        w_sb_clear;
  logic                        w_hazard;
  logic                        w_valid;
  logic                        w_issue;
  logic                        w_enq;

  // Head decode
  assign w_head   = r_mem[r_rd_ptr];
  assign w_dst    = w_head[DST_LSB  +: REGISTER_BITS];
  assign w_src1   = w_head[SRC1_LSB +: REGISTER_BITS];
  assign w_src2   = w_head[SRC2_LSB +: REGISTER_BITS];
  assign w_lock   = w_head[LOCK_BIT];
  assign w_reconf = w_head[RECONF_BIT];
  assign w_store  = (w_head[UOP_LSB + instr_opcode_msb_c -: 3] == OPC_STORE);

  assign w_empty    = (r_count == '0);
  assign w_sb_clear = (r_pending == '0) && (r_locked == '0);

  // Conservative hazard: all three register fields are checked regardless of
  // whether the opcode actually reads src2 or dst.
  assign w_hazard = r_pending[w_src1] | r_pending[w_src2] | r_pending[w_dst] |
                    r_locked[w_src1]  | r_locked[w_src2]  | r_locked[w_dst];

  // Issue FSM: valid depends only on registered state, never on valid_i/ready_i.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    case (r_state)
      RUN: begin
        if (!w_empty) begin
          if (w_reconf) begin
            w_state_nxt = DRAIN;
          end else begin
            w_valid = !w_hazard;
          end
        end
      end
      DRAIN: begin
        w_valid = !w_empty && w_sb_clear;
        if (w_valid && ready_i) begin
          w_state_nxt = RUN;
        end
      end
    endcase
    if (flush_i) begin
      w_state_nxt = RUN;
    end
  end

  // A flush cycle discards any handshake that happens to coincide with it.
  assign w_issue = w_valid && ready_i && !flush_i;
  assign w_enq   = valid_i && ready_o && !flush_i;

  // Scoreboard update: clears first, then sets, so a same-cycle set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    w_locked_nxt  = r_locked;
    if (wb_valid_i) begin
      w_pending_nxt[wb_dst_i] = 1'b0;
    end
    if (unlock_valid_i) begin
      w_locked_nxt[unlock_dst_i] = 1'b0;
    end
    if (w_issue && !w_reconf) begin
      if (!w_store) begin
        w_pending_nxt[w_dst] = 1'b1;
      end
      if (w_lock) begin
        w_locked_nxt[w_dst] = 1'b1;
      end
    end
    if (flush_i) begin
      w_pending_nxt = '0;
      w_locked_nxt  = '0;
    end
  end

  // Control state: FSM, scoreboard, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= RUN;
      r_pending <= '0;
      r_locked  <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_locked  <= w_locked_nxt;
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_enq, w_issue})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage carries data only; contents are don't-care while not valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= instr_i;
    end
  end

  // ready_o comes from the registered count only: no pass-through when full.
  assign ready_o   = (r_count < DEPTH_C);
  assign valid_o   = w_valid;
  assign instr_o   = w_head;
  assign count_o   = r_count;
  assign is_idle_o = w_empty && w_sb_clear;

endmodule
